// File: rtl/cpu_sequencer.sv
// cpu_sequencer: 8-phase control unit for the accumulator CPU.
// Adds a memory-ready handshake with stall counting, a sticky wait-timeout
// fault, halt/resume and single-step gating at the start of each instruction.
module cpu_sequencer #(
  parameter int OPW           = 3,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int WAIT_MAX      = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  input  logic           resume,
  input  logic           step_en,
  input  logic           step,
  output logic           sel,
  output logic           rd,
  output logic           ld_ir,
  output logic           inc_pc,
  output logic           halt,
  output logic           ld_pc,
  output logic           data_e,
  output logic           ld_ac,
  output logic           wr,
  output logic [2:0]     phase,
  output logic           timeout
);

  localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] WMAX = CW'(WAIT_MAX);

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_FAULT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  // Opcode classes; anything outside 0..7 matches none of them (NOP).
  logic op_hlt, op_skz, op_jmp, op_sto, op_alu;
  assign op_hlt = (opcode == OPW'(0));
  assign op_skz = (opcode == OPW'(1));
  assign op_jmp = (opcode == OPW'(7));
  assign op_sto = (opcode == OPW'(6));
  assign op_alu = (opcode >= OPW'(2)) && (opcode <= OPW'(5));

  // Raw RUN-mode strobe decode from phase and opcode, before state gating.
  logic sel_r, rd_r, ld_ir_r, inc_pc_r, halt_r, ld_pc_r, data_e_r, ld_ac_r, wr_r;
  always_comb begin
    sel_r = 1'b0; rd_r = 1'b0; ld_ir_r = 1'b0; inc_pc_r = 1'b0; halt_r = 1'b0;
    ld_pc_r = 1'b0; data_e_r = 1'b0; ld_ac_r = 1'b0; wr_r = 1'b0;
    case (phase_q)
      3'd0: sel_r = 1'b1;
      3'd1: begin sel_r = 1'b1; rd_r = 1'b1; end
      3'd2, 3'd3: begin sel_r = 1'b1; rd_r = 1'b1; ld_ir_r = 1'b1; end
      3'd4: begin inc_pc_r = 1'b1; halt_r = op_hlt; end
      3'd5: rd_r = op_alu;
      3'd6: begin
        rd_r     = op_alu;
        inc_pc_r = op_skz & zero;
        ld_pc_r  = op_jmp;
        data_e_r = op_sto;
      end
      3'd7: begin
        rd_r     = op_alu;
        ld_ac_r  = op_alu;
        ld_pc_r  = op_jmp;
        data_e_r = op_sto;
        wr_r     = op_sto;
      end
      default: ;
    endcase
  end

  // Strobes only leave the chip in RUN; HALTED shows halt alone; reset kills all.
  logic in_run, in_halt;
  assign in_run  = !rst && (state_q == S_RUN);
  assign in_halt = !rst && (state_q == S_HALTED);

  assign sel     = in_run & sel_r;
  assign rd      = in_run & rd_r;
  assign ld_ir   = in_run & ld_ir_r;
  assign inc_pc  = in_run & inc_pc_r;
  assign halt    = (in_run & halt_r) | in_halt;
  assign ld_pc   = in_run & ld_pc_r;
  assign data_e  = in_run & data_e_r;
  assign ld_ac   = in_run & ld_ac_r;
  assign wr      = in_run & wr_r;
  assign phase   = phase_q;
  assign timeout = to_q;

  // A memory phase is any phase that reads or writes; it stalls on !mem_ready.
  logic stall;
  assign stall = MEM_HANDSHAKE && (rd_r || wr_r) && !mem_ready;

  // Next state: phase advance, stall counting/timeout, halt, resume, step gate.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      S_RUN: begin
        if (stall) begin
          if ((WAIT_MAX > 0) && (cnt_q == WMAX)) begin
            state_d = S_FAULT;
            to_d    = 1'b1;
          end else if (cnt_q != WMAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
          if (phase_q == 3'd4 && op_hlt) begin
            state_d = S_HALTED;
          end else if (!(phase_q == 3'd0 && step_en && !step)) begin
            phase_d = phase_q + 3'd1;
          end
        end
      end
      S_HALTED: begin
        // HLT finishes its phases 5-7 inertly, then the next fetch starts.
        if (resume) begin
          state_d = S_RUN;
          phase_d = 3'd5;
        end
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      phase_q <= 3'd0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a driver issues per-cycle stimulus and
// pushes the reference model's expected outputs; a monitor pops and compares.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0, mem_ready = 1'b1, resume = 1'b0, step_en = 1'b0, step = 1'b0;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase;
  logic       timeout;

  always #5 clk = ~clk;

  cpu_sequencer #(.OPW(3), .MEM_HANDSHAKE(1'b1), .WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .resume(resume), .step_en(step_en), .step(step),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt),
    .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac), .wr(wr),
    .phase(phase), .timeout(timeout)
  );

  typedef struct packed {
    logic       known;
    logic [8:0] stb;   // {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}
    logic [2:0] ph;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: mode 0=running, 1=halted, 2=faulted.
  int m_mode = 0, m_phase = 0, m_stall = 0;
  bit m_to = 1'b0, m_known = 1'b0;

  // Strobe table written straight from the per-phase rules.
  function automatic logic [8:0] ref_stb(input int mode, input int ph, input int op,
                                         input bit z, input bit r);
    bit alu;
    logic [8:0] s;
    alu = (op >= 2) && (op <= 5);
    s = '0;
    if (r || mode == 2) return s;
    if (mode == 1) return 9'b0_0001_0000;
    s[8] = (ph <= 3);
    s[7] = (ph >= 1 && ph <= 3) || (alu && ph >= 5);
    s[6] = (ph == 2 || ph == 3);
    s[5] = (ph == 4) || (op == 1 && z && ph == 6);
    s[4] = (ph == 4 && op == 0);
    s[3] = (op == 7 && ph >= 6);
    s[2] = (op == 6 && ph >= 6);
    s[1] = (alu && ph == 7);
    s[0] = (op == 6 && ph == 7);
    return s;
  endfunction

  // One clock of stimulus: drive, record expectation, advance the model.
  task automatic cyc(input bit r, input int op, input bit z, input bit rdy,
                     input bit res, input bit sen, input bit stp);
    exp_t e;
    logic [8:0] s;
    @(negedge clk);
    rst = r; opcode = op[2:0]; zero = z; mem_ready = rdy;
    resume = res; step_en = sen; step = stp;
    #1;
    s = ref_stb(m_mode, m_phase, op, z, r);
    e.known = m_known; e.stb = s; e.ph = m_phase[2:0]; e.to = m_to;
    sb.push_back(e);
    if (r) begin
      m_mode = 0; m_phase = 0; m_stall = 0; m_to = 1'b0; m_known = 1'b1;
    end else if (m_known) begin
      if (m_mode == 0) begin
        if ((s[7] || s[0]) && !rdy) begin
          if (m_stall == 15) begin m_mode = 2; m_to = 1'b1; end
          else m_stall++;
        end else begin
          m_stall = 0;
          if (m_phase == 4 && op == 0) m_mode = 1;
          else if (m_phase == 0 && sen && !stp) m_phase = 0;
          else m_phase = (m_phase + 1) % 8;
        end
      end else if (m_mode == 1 && res) begin
        m_mode = 0; m_phase = 5;
      end
    end
  endtask

  task automatic run(input int op, input bit sen);
    cyc(1'b0, op, 1'b0, 1'b1, 1'b0, sen, 1'b0);
  endtask

  // Steps the machine (ready, no step mode) until the model sits at a phase.
  task automatic goto_phase(input int target, input int op);
    for (int k = 0; k < 40 && !(m_mode == 0 && m_phase == target); k++) run(op, 1'b0);
  endtask

  // Direct point check of an observed condition.
  task automatic chk(input bit ok, input string what);
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: stb=%b ph=%0d to=%b", what,
               {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}, phase, timeout);
    end
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  exp_t       mon_e;
  logic [8:0] mon_s;
  always begin
    @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_s = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
      n_vec++;
      if (mon_e.known ? ({mon_s, phase, timeout} !== {mon_e.stb, mon_e.ph, mon_e.to})
                      : (mon_s !== mon_e.stb)) begin
        n_bad++;
        $display("FAIL vec%0d outputs: got stb=%b ph=%0d to=%b, want stb=%b ph=%0d to=%b",
                 n_vec, mon_s, phase, timeout, mon_e.stb, mon_e.ph, mon_e.to);
      end
    end
  end

  initial begin
    // Reset, then one clean ALU instruction and a wrap.
    repeat (2) cyc(1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk((phase === 3'd0) && (timeout === 1'b0) &&
        ({sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr} === 9'd0),
        "reset state");
    repeat (10) run(2, 1'b0);
    // SKZ with zero=1 / zero=0, JMP, STO over whole instructions.
    repeat (8) cyc(1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8) run(7, 1'b0);
    repeat (8) run(6, 1'b0);
    // Short stall at phase 1 under LDA.
    goto_phase(1, 5);
    repeat (3) cyc(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) run(5, 1'b0);
    // Ready arrives on the cycle the counter reaches its limit: no fault.
    goto_phase(1, 5);
    repeat (15) cyc(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) run(5, 1'b0);
    // Stall that persists: fault, sticky until reset.
    goto_phase(1, 5);
    repeat (20) cyc(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk((timeout === 1'b1) && (phase === 3'd1) &&
        ({sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr} === 9'd0),
        "expired wait");
    repeat (5) cyc(1'b0, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // HLT, long halt, resume together with step.
    goto_phase(4, 2);
    repeat (20) run(0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (4) run(2, 1'b0);
    // Step mode: hold, one step, step at phase 3 ignored.
    goto_phase(0, 3);
    repeat (10) run(3, 1'b1);
    cyc(1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run(3, 1'b1); run(3, 1'b1);
    cyc(1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (10) run(3, 1'b1);
    // Randomised mix, normal mode then step mode then everything with resets.
    for (int i = 0; i < 400; i++)
      cyc(1'b0, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 99) < 80,
          $urandom_range(0, 99) < 10, 1'b0, $urandom_range(0, 1));
    for (int i = 0; i < 300; i++)
      cyc(1'b0, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 99) < 80,
          $urandom_range(0, 99) < 10, 1'b1, $urandom_range(0, 99) < 15);
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 99) < 1, $urandom_range(0, 7), $urandom_range(0, 1),
          $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
